// File: rtl/retire_trace_fifo_if.sv
// Retire-side and trace-side handshake bundle for the retirement trace buffer.
// The FIFO uses the slave view (consumes retires, produces trace records).
// The core/consumer side uses the master view.
interface retire_trace_fifo_if #(
  parameter int XLEN = 32
);
  // retire side (core -> fifo)
  logic            ret_valid_i;
  logic [XLEN-1:0] ret_pc_i;
  logic [31:0]     ret_instr_i;
  logic [4:0]      ret_rd_i;
  logic [XLEN-1:0] ret_rd_data_i;
  logic [XLEN-1:0] ret_mem_addr_i;
  logic [XLEN-1:0] ret_mem_data_i;
  logic            ret_mem_wrt_i;
  // trace side (fifo -> consumer)
  logic            trace_valid_o;
  logic            trace_ready_i;
  logic [XLEN-1:0] trace_pc_o;
  logic [31:0]     trace_instr_o;
  logic [4:0]      trace_rd_o;
  logic [XLEN-1:0] trace_rd_data_o;
  logic [XLEN-1:0] trace_mem_addr_o;
  logic [XLEN-1:0] trace_mem_data_o;
  logic            trace_mem_wrt_o;

  modport master (
    output ret_valid_i, ret_pc_i, ret_instr_i, ret_rd_i, ret_rd_data_i,
           ret_mem_addr_i, ret_mem_data_i, ret_mem_wrt_i, trace_ready_i,
    input  trace_valid_o, trace_pc_o, trace_instr_o, trace_rd_o,
           trace_rd_data_o, trace_mem_addr_o, trace_mem_data_o, trace_mem_wrt_o
  );

  modport slave (
    input  ret_valid_i, ret_pc_i, ret_instr_i, ret_rd_i, ret_rd_data_i,
           ret_mem_addr_i, ret_mem_data_i, ret_mem_wrt_i, trace_ready_i,
    output trace_valid_o, trace_pc_o, trace_instr_o, trace_rd_o,
           trace_rd_data_o, trace_mem_addr_o, trace_mem_data_o, trace_mem_wrt_o
  );
endinterface

// File: rtl/retire_trace_fifo.sv
// Retirement trace buffer: filters each retired record (rd squashed for
// branch/store), stops tracing once the halt PC retires, and queues records
// in a DEPTH-entry FIFO drained over valid/ready. Overflow drops are counted.
module retire_trace_fifo #(
  parameter int              XLEN    = 32,
  parameter int              DEPTH   = 8,
  parameter logic [XLEN-1:0] HALT_PC = 32'h8000_20C8,
  parameter bit              HALT_EN = 1'b1,
  localparam int             AW      = $clog2(DEPTH),
  localparam int             CW      = AW + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  retire_trace_fifo_if.slave  bus,
  output logic [CW-1:0]       count_o,
  output logic                halted_o,
  output logic                overflow_o,
  output logic [15:0]         drop_cnt_o
);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [6:0]    OP_BRANCH = 7'b1100011;
  localparam logic [6:0]    OP_STORE  = 7'b0100011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            mem_wrt;
  } rec_t;

  typedef enum logic {RUN, HALTED} state_t;

  state_t        state, state_nxt;
  rec_t          mem [DEPTH];
  rec_t          rec_in, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   drop_cnt;
  logic          overflow;
  logic          is_halt, push_try, push, pop, drop, full, no_rd;

  // Filter: branches and stores have no destination, so rd/rd_data are zeroed.
  always_comb begin
    no_rd           = (bus.ret_instr_i[6:0] == OP_BRANCH) ||
                      (bus.ret_instr_i[6:0] == OP_STORE);
    rec_in.pc       = bus.ret_pc_i;
    rec_in.instr    = bus.ret_instr_i;
    rec_in.rd       = no_rd ? 5'd0 : bus.ret_rd_i;
    rec_in.rd_data  = (rec_in.rd == 5'd0) ? '0 : bus.ret_rd_data_i;
    rec_in.mem_addr = bus.ret_mem_addr_i;
    rec_in.mem_data = bus.ret_mem_data_i;
    rec_in.mem_wrt  = bus.ret_mem_wrt_i;
  end

  // Halt FSM next state plus push/pop/drop qualification.
  always_comb begin
    state_nxt = state;
    push_try  = 1'b0;
    is_halt   = HALT_EN && (bus.ret_pc_i == HALT_PC);
    if (state == RUN && bus.ret_valid_i) begin
      if (is_halt) state_nxt = HALTED;
      else         push_try  = 1'b1;
    end
    full = (count == FULL_CNT);
    pop  = (count != '0) && bus.trace_ready_i;
    push = push_try && (!full || pop);
    drop = push_try && full && !pop;
  end

  // FSM state register; reset and flush both return to RUN.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) state <= RUN;
    else                  state <= state_nxt;
  end

  // Pointers, occupancy and overflow status.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= rec_in;
  end

  assign head                 = mem[rd_ptr];
  assign bus.trace_valid_o    = (count != '0);
  assign bus.trace_pc_o       = head.pc;
  assign bus.trace_instr_o    = head.instr;
  assign bus.trace_rd_o       = head.rd;
  assign bus.trace_rd_data_o  = head.rd_data;
  assign bus.trace_mem_addr_o = head.mem_addr;
  assign bus.trace_mem_data_o = head.mem_data;
  assign bus.trace_mem_wrt_o  = head.mem_wrt;
  assign count_o              = count;
  assign halted_o             = (state == HALTED);
  assign overflow_o           = overflow;
  assign drop_cnt_o           = drop_cnt;
endmodule

// File: tb/tb_retire_trace_fifo.sv
// Directed bench for retire_trace_fifo: ordering, filtering, overflow,
// full push+pop with pointer wrap, halt handling (enabled and disabled), reset.
module tb_retire_trace_fifo;
  localparam int XLEN = 32;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst_i, flush_i;
  logic [CW-1:0] count_o, count2;
  logic          halted_o, overflow_o, halted2, overflow2;
  logic [15:0]   drop_cnt_o, drop2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  retire_trace_fifo_if #(.XLEN(XLEN)) b ();
  retire_trace_fifo_if #(.XLEN(XLEN)) b2 ();

  retire_trace_fifo #(.XLEN(XLEN), .DEPTH(8), .HALT_PC(32'h8000_20C8), .HALT_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .bus(b),
    .count_o(count_o), .halted_o(halted_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  retire_trace_fifo #(.XLEN(XLEN), .DEPTH(8), .HALT_PC(32'h8000_20C8), .HALT_EN(1'b0)) dut_nh (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .bus(b2),
    .count_o(count2), .halted_o(halted2), .overflow_o(overflow2), .drop_cnt_o(drop2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ret(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] rd,
                     input logic [31:0] rdd, input logic [31:0] addr, input logic [31:0] data,
                     input logic wrt);
    b.ret_valid_i    = 1'b1;
    b.ret_pc_i       = pc;
    b.ret_instr_i    = instr;
    b.ret_rd_i       = rd;
    b.ret_rd_data_i  = rdd;
    b.ret_mem_addr_i = addr;
    b.ret_mem_data_i = data;
    b.ret_mem_wrt_i  = wrt;
  endtask

  task automatic alu(input logic [31:0] pc, input logic [31:0] rdd);
    ret(pc, 32'h0000_0293, 5'd5, rdd, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic idle();
    b.ret_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0;
    idle(); alu(32'h0, 32'h0); idle();
    b.trace_ready_i = 1'b0;
    b2.ret_valid_i = 1'b0; b2.ret_pc_i = '0; b2.ret_instr_i = '0; b2.ret_rd_i = '0;
    b2.ret_rd_data_i = '0; b2.ret_mem_addr_i = '0; b2.ret_mem_data_i = '0;
    b2.ret_mem_wrt_i = 1'b0; b2.trace_ready_i = 1'b0;
    step(); step();
    rst_i = 1'b0;

    // reset state
    chk("rst_count", count_o, 0);
    chk("rst_valid", b.trace_valid_o, 0);
    chk("rst_halted", halted_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_drop", drop_cnt_o, 0);

    // back-to-back ALU retires with ready high
    b.trace_ready_i = 1'b1;
    alu(32'h8000_0000, 32'h11);
    chk("t1_valid_pre", b.trace_valid_o, 0);
    step();
    chk("t1_valid0", b.trace_valid_o, 1);
    chk("t1_pc0", b.trace_pc_o, 32'h8000_0000);
    chk("t1_rd0", b.trace_rd_o, 5);
    chk("t1_rdd0", b.trace_rd_data_o, 32'h11);
    alu(32'h8000_0004, 32'h22);
    step();
    chk("t1_pc1", b.trace_pc_o, 32'h8000_0004);
    chk("t1_rdd1", b.trace_rd_data_o, 32'h22);
    chk("t1_cnt1", count_o, 1);
    alu(32'h8000_0008, 32'h33);
    step();
    chk("t1_pc2", b.trace_pc_o, 32'h8000_0008);
    chk("t1_rdd2", b.trace_rd_data_o, 32'h33);
    chk("t1_cnt2", count_o, 1);
    idle();
    step();
    chk("t1_empty", b.trace_valid_o, 0);

    // branch and store: rd filtered out
    ret(32'h8000_000C, 32'h0020_8463, 5'd8, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0);
    step();
    chk("t2_br_rd", b.trace_rd_o, 0);
    chk("t2_br_rdd", b.trace_rd_data_o, 0);
    chk("t2_br_instr", b.trace_instr_o, 32'h0020_8463);
    ret(32'h8000_0010, 32'h0020_A023, 5'd3, 32'h1234_5678, 32'h0000_1000, 32'h0000_CAFE, 1'b1);
    step();
    chk("t2_st_pc", b.trace_pc_o, 32'h8000_0010);
    chk("t2_st_rd", b.trace_rd_o, 0);
    chk("t2_st_rdd", b.trace_rd_data_o, 0);
    chk("t2_st_wrt", b.trace_mem_wrt_o, 1);
    chk("t2_st_addr", b.trace_mem_addr_o, 32'h1000);
    chk("t2_st_data", b.trace_mem_data_o, 32'hCAFE);
    idle();
    step();
    chk("t2_empty", count_o, 0);

    // overflow: 10 retires into 8 entries with ready low
    b.trace_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      alu(32'h100 + 32'(4 * i), 32'(i + 1));
      step();
    end
    idle();
    chk("t3_count", count_o, 8);
    chk("t3_overflow", overflow_o, 1);
    chk("t3_drop", drop_cnt_o, 2);
    b.trace_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_drain_pc", b.trace_pc_o, 32'h100 + 32'(4 * i));
      step();
    end
    chk("t3_drained", count_o, 0);
    chk("t3_ovf_sticky", overflow_o, 1);
    chk("t3_drop_hold", drop_cnt_o, 2);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("t3_flush_ovf", overflow_o, 0);
    chk("t3_flush_drop", drop_cnt_o, 0);

    // move pointers to 7 by streaming 7 records through, then fill and push+pop
    for (int i = 0; i < 7; i++) begin
      alu(32'h200 + 32'(4 * i), 32'h1);
      step();
    end
    idle();
    chk("t4_stream_cnt", count_o, 1);
    step();
    chk("t4_empty", count_o, 0);
    b.trace_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      alu(32'h300 + 32'(4 * i), 32'h1);
      step();
    end
    chk("t4_full", count_o, 8);
    chk("t4_head", b.trace_pc_o, 32'h300);
    alu(32'h400, 32'h44);
    b.trace_ready_i = 1'b1;
    step();
    idle();
    chk("t4_pp_count", count_o, 8);
    chk("t4_pp_drop", drop_cnt_o, 0);
    chk("t4_pp_ovf", overflow_o, 0);
    for (int i = 1; i < 8; i++) begin
      chk("t4_drain_pc", b.trace_pc_o, 32'h300 + 32'(4 * i));
      step();
    end
    chk("t4_wrap_pc", b.trace_pc_o, 32'h400);
    chk("t4_wrap_rdd", b.trace_rd_data_o, 32'h44);
    step();
    chk("t4_drained", count_o, 0);

    // halt with two records queued
    b.trace_ready_i = 1'b0;
    alu(32'h500, 32'h1); step();
    alu(32'h504, 32'h2); step();
    alu(32'h8000_20C8, 32'h3);
    chk("t5_pre_halt", halted_o, 0);
    step();
    chk("t5_halted", halted_o, 1);
    chk("t5_not_queued", count_o, 2);
    alu(32'h508, 32'h4); step();
    alu(32'h50C, 32'h5); step();
    idle();
    chk("t5_ignored", count_o, 2);
    chk("t5_no_drop", drop_cnt_o, 0);
    b.trace_ready_i = 1'b1;
    chk("t5_drain0", b.trace_pc_o, 32'h500);
    step();
    chk("t5_drain1", b.trace_pc_o, 32'h504);
    step();
    chk("t5_empty", b.trace_valid_o, 0);
    chk("t5_still_halted", halted_o, 1);

    // halt-disabled instance queues the halt PC
    b2.ret_valid_i = 1'b1; b2.ret_pc_i = 32'h8000_20C8; b2.ret_rd_i = 5'd7;
    b2.ret_rd_data_i = 32'h77; b2.ret_instr_i = 32'h0000_0393;
    step();
    b2.ret_valid_i = 1'b0;
    chk("t5_nh_count", count2, 1);
    chk("t5_nh_pc", b2.trace_pc_o, 32'h8000_20C8);
    chk("t5_nh_halted", halted2, 0);

    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("t5_flush_halt", halted_o, 0);

    // reset mid-drain with 5 entries queued (and drops recorded)
    b.trace_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      alu(32'h600 + 32'(4 * i), 32'h1);
      step();
    end
    idle();
    b.trace_ready_i = 1'b1;
    step(); step(); step();
    chk("t6_pre_count", count_o, 5);
    chk("t6_pre_drop", drop_cnt_o, 2);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("t6_count", count_o, 0);
    chk("t6_valid", b.trace_valid_o, 0);
    chk("t6_halted", halted_o, 0);
    chk("t6_drop", drop_cnt_o, 0);
    chk("t6_ovf", overflow_o, 0);
    b.trace_ready_i = 1'b0;
    alu(32'h700, 32'h9);
    step();
    idle();
    chk("t6_push_valid", b.trace_valid_o, 1);
    chk("t6_push_pc", b.trace_pc_o, 32'h700);
    chk("t6_push_count", count_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
